sync_general_arbiter: RTL and testbench

- Round-robin arbiter/sequencer sharing one sync_general compute unit among N_REQ requesters.
- Latches the winning requester's operand and pulses the unit's Start for one cycle.
- Waits for the unit's Ready, captures Dout/Error, returns them to the winner with a one-cycle Done.
- Sits between requester logic and a single sync_general instance; the unit's ports connect 1:1 to the U_* ports.

---
 rtl/sync_general_arbiter.sv | 98 +++++++++
 tb/tb_sync_general_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_general_arbiter.sv
// sync_general_arbiter: round-robin sequencer sharing one sync_general unit among N_REQ requesters.
// Optional WAIT timeout enabled by defining ARB_TIMEOUT_EN.
module sync_general_arbiter #(
    parameter int data_bits = 6,
    parameter int N_REQ = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [N_REQ-1:0]           Req,
    input  logic [N_REQ*data_bits-1:0] Din_bus,
    output logic [N_REQ-1:0]           Grant,
    output logic [N_REQ-1:0]           Done,
    output logic [data_bits-1:0]       Dout,
    output logic                       Error,
    output logic                       Busy,
    output logic                       U_Start,
    output logic [data_bits-1:0]       U_Din,
    input  logic [data_bits-1:0]       U_Dout,
    input  logic                       U_Ready,
    input  logic                       U_Error
);
    localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, nstate;
    logic [IW-1:0] ptr, idx, win, j;
    logic found, tmo;
    int k;
`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
    assign tmo = state == WAIT && !U_Ready && tcnt == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge Clk) begin
        if (Reset || state == ISSUE)
            tcnt <= '0;
        else if (state == WAIT && !U_Ready)
            tcnt <= tcnt + 1'b1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES[0];
    assign tmo = 1'b0;
`endif
    // first set request at or after ptr, wrapping
    always_comb begin
        found = 1'b0;
        win = '0;
        j = '0;
        k = 0;
        for (int i = 0; i < N_REQ; i++) begin
            k = int'(ptr) + i;
            if (k >= N_REQ) k = k - N_REQ;
            j = IW'(k);
            if (!found && Req[j]) begin
                found = 1'b1;
                win = j;
            end
        end
    end
    always_comb begin
        nstate = state;
        Busy = state != IDLE;
        U_Start = state == ISSUE;
        Grant = Busy ? N_REQ'(1) << idx : '0;
        Done = state == RESP ? N_REQ'(1) << idx : '0;
        unique case (state)
            IDLE:    nstate = found ? ISSUE : IDLE;
            ISSUE:   nstate = WAIT;
            WAIT:    nstate = (U_Ready || tmo) ? RESP : WAIT;
            default: nstate = IDLE;
        endcase
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            ptr <= '0;
            idx <= '0;
            U_Din <= '0;
            Dout <= '0;
            Error <= 1'b0;
        end else begin
            state <= nstate;
            if (state == IDLE && found) begin
                idx <= win;
                U_Din <= Din_bus[int'(win)*data_bits +: data_bits];
            end
            if (state == WAIT && U_Ready) begin
                Dout <= U_Dout;
                Error <= U_Error;
            end else if (tmo) begin
                Dout <= '0;
                Error <= 1'b1;
            end
            if (state == RESP)
                ptr <= idx == IW'(N_REQ - 1) ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_sync_general_arbiter.sv
// tb_sync_general_arbiter: vector table plus scoreboard queues for sync_general_arbiter.
module tb_sync_general_arbiter;
    logic Clk = 1'b0;
    logic Reset;
    logic [2:0] Req;
    logic [17:0] Din_bus;
    logic [2:0] Grant, Done;
    logic [5:0] Dout, U_Din, U_Dout;
    logic Error, Busy, U_Start, U_Ready, U_Error;
    int checks = 0;
    int errors = 0;
    int ulat = 0;
    int ucnt = 0;
    int ndone = 0;
    int n, d0;
    logic seen;
    typedef struct {
        logic [2:0] req;
        logic [17:0] din;
        int lat;
        logic [5:0] udout;
        logic uerr;
        logic [2:0] exp_done;
        logic [5:0] exp_op;
    } vec_t;
    typedef struct {
        logic [2:0] done;
        logic [5:0] dout;
        logic err;
    } res_t;
    vec_t vecs[7];
    res_t resq[$];
    res_t r;
    logic [5:0] opq[$];

    sync_general_arbiter #(.data_bits(6), .N_REQ(3), .TIMEOUT_CYCLES(16)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Din_bus(Din_bus),
        .Grant(Grant), .Done(Done), .Dout(Dout), .Error(Error), .Busy(Busy),
        .U_Start(U_Start), .U_Din(U_Din), .U_Dout(U_Dout),
        .U_Ready(U_Ready), .U_Error(U_Error)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_res(input logic [2:0] dn, input logic [5:0] dv, input logic e);
        res_t x;
        x.done = dn;
        x.dout = dv;
        x.err = e;
        resq.push_back(x);
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            @(negedge Clk);
            cnt++;
        end while (Done == 0 && cnt < 60);
        if (Done == 0) begin
            checks++;
            errors++;
            $display("FAIL wait_done: no Done within 60 cycles");
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // unit model: Ready after ulat stalled WAIT cycles, never when ulat < 0
    always @(posedge Clk) begin
        if (Reset) begin
            U_Ready <= 1'b0;
            ucnt <= 0;
        end else if (U_Start) begin
            U_Ready <= ulat == 0;
            ucnt <= ulat;
        end else begin
            U_Ready <= ucnt == 1;
            if (ucnt > 0) ucnt <= ucnt - 1;
        end
    end

    always @(negedge Clk) begin
        if (!Reset && U_Start) begin
            if (opq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u_start: unexpected start, U_Din %0h", U_Din);
            end else
                chk("u_din", 32'(U_Din), 32'(opq.pop_front()));
        end
        if (!Reset && Done != 0) begin
            ndone++;
            if (resq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done: unexpected Done %b", Done);
            end else begin
                r = resq.pop_front();
                chk("done", 32'(Done), 32'(r.done));
                chk("grant_at_done", 32'(Grant), 32'(r.done));
                chk("dout", 32'(Dout), 32'(r.dout));
                chk("error", 32'(Error), 32'(r.err));
            end
        end
    end

    initial begin
        Reset = 1'b1;
        Req = '0;
        Din_bus = '0;
        U_Dout = '0;
        U_Error = 1'b0;
        vecs[0] = '{3'b010, {6'h00, 6'h15, 6'h00}, 0, 6'h2A, 1'b0, 3'b010, 6'h15};
        vecs[1] = '{3'b111, {6'h03, 6'h02, 6'h01}, 2, 6'h11, 1'b0, 3'b100, 6'h03};
        vecs[2] = '{3'b011, {6'h3F, 6'h22, 6'h33}, 1, 6'h05, 1'b1, 3'b001, 6'h33};
        vecs[3] = '{3'b101, {6'h0A, 6'h0B, 6'h0C}, 0, 6'h3F, 1'b0, 3'b100, 6'h0A};
        vecs[4] = '{3'b110, {6'h21, 6'h12, 6'h00}, 3, 6'h00, 1'b1, 3'b010, 6'h12};
        vecs[5] = '{3'b001, {6'h00, 6'h00, 6'h2D}, 0, 6'h1B, 1'b0, 3'b001, 6'h2D};
        vecs[6] = '{3'b011, {6'h01, 6'h02, 6'h03}, 0, 6'h2E, 1'b0, 3'b010, 6'h02};
        repeat (2) @(negedge Clk);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_grant", 32'(Grant), 0);
        chk("rst_done", 32'(Done), 0);
        chk("rst_start", 32'(U_Start), 0);
        chk("rst_udin", 32'(U_Din), 0);
        chk("rst_dout", 32'(Dout), 0);
        chk("rst_error", 32'(Error), 0);
        Reset = 1'b0;
        @(negedge Clk);
        for (int v = 0; v < 7; v++) begin
            Req = vecs[v].req;
            Din_bus = vecs[v].din;
            ulat = vecs[v].lat;
            U_Dout = vecs[v].udout;
            U_Error = vecs[v].uerr;
            opq.push_back(vecs[v].exp_op);
            expect_res(vecs[v].exp_done, vecs[v].udout, vecs[v].uerr);
            wait_done(n);
            chk("latency", 32'(n), 32'(3 + vecs[v].lat));
            Req = '0;
            @(negedge Clk);
            chk("busy_idle", 32'(Busy), 0);
        end

        do_reset();
        Din_bus = {6'h03, 6'h02, 6'h01};
        ulat = 0;
        U_Dout = 6'h19;
        U_Error = 1'b0;
        for (int t = 0; t < 4; t++) begin
            opq.push_back(6'(t % 3 + 1));
            expect_res(3'b001 << (t % 3), 6'h19, 1'b0);
        end
        Req = 3'b111;
        for (int t = 0; t < 4; t++) begin
            wait_done(n);
            chk(t == 0 ? "fair_latency" : "b2b_spacing", 32'(n), t == 0 ? 3 : 4);
        end
        Req = '0;
        @(negedge Clk);
        chk("fair_busy_idle", 32'(Busy), 0);

        Req = 3'b100;
        Din_bus = {6'h2B, 6'h00, 6'h00};
        ulat = 2;
        U_Dout = 6'h07;
        U_Error = 1'b1;
        opq.push_back(6'h2B);
        expect_res(3'b100, 6'h07, 1'b1);
        repeat (2) @(negedge Clk);
        Req = '0;
        wait_done(n);
        chk("drop_latency", 32'(n), 3);
        @(negedge Clk);
        chk("drop_busy1", 32'(Busy), 0);
        @(negedge Clk);
        chk("drop_busy2", 32'(Busy), 0);

        Req = 3'b001;
        Din_bus = {6'h00, 6'h00, 6'h01};
        ulat = 3;
        U_Dout = 6'h3C;
        U_Error = 1'b0;
        opq.push_back(6'h01);
        expect_res(3'b001, 6'h3C, 1'b0);
        repeat (2) @(negedge Clk);
        Din_bus = {6'h00, 6'h00, 6'h3F};
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge Clk);
            chk("u_din_hold", 32'(U_Din), 32'h01);
            seen = Done != 0;
        end
        chk("stab_done_seen", 32'(seen), 1);
        Req = '0;
        @(negedge Clk);

        Req = 3'b001;
        Din_bus = {6'h00, 6'h00, 6'h01};
        ulat = -1;
        opq.push_back(6'h01);
        repeat (4) @(negedge Clk);
        chk("stall_busy", 32'(Busy), 1);
        Reset = 1'b1;
        @(negedge Clk);
        chk("midrst_busy", 32'(Busy), 0);
        chk("midrst_grant", 32'(Grant), 0);
        chk("midrst_done", 32'(Done), 0);
        chk("midrst_udin", 32'(U_Din), 0);
        chk("midrst_dout", 32'(Dout), 0);
        Reset = 1'b0;
        Req = '0;
        d0 = ndone;
        repeat (10) @(negedge Clk);
        chk("midrst_no_done", 32'(ndone), 32'(d0));

`ifdef ARB_TIMEOUT_EN
        Req = 3'b010;
        Din_bus = {6'h00, 6'h0E, 6'h00};
        ulat = -1;
        U_Dout = 6'h33;
        U_Error = 1'b0;
        opq.push_back(6'h0E);
        expect_res(3'b010, 6'h00, 1'b1);
        wait_done(n);
        chk("timeout_latency", 32'(n), 18);
        Req = '0;
        @(negedge Clk);
        Req = 3'b010;
        ulat = 15;
        U_Dout = 6'h2C;
        opq.push_back(6'h0E);
        expect_res(3'b010, 6'h2C, 1'b0);
        wait_done(n);
        chk("limit_ready_latency", 32'(n), 18);
        Req = '0;
        @(negedge Clk);
`else
        Req = 3'b010;
        Din_bus = {6'h00, 6'h0E, 6'h00};
        ulat = -1;
        opq.push_back(6'h0E);
        d0 = ndone;
        repeat (40) @(negedge Clk);
        chk("hold_busy", 32'(Busy), 1);
        chk("hold_no_done", 32'(ndone), 32'(d0));
        Req = '0;
        do_reset();
        @(negedge Clk);
`endif
        chk("opq_empty", 32'(opq.size()), 0);
        chk("resq_empty", 32'(resq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
